update_knn_acc_topk: RTL and testbench

Distance accumulator and top-K selector that sits directly downstream of the KNN unsigned product multiplier. It sums a stream of 32-bit products into one distance per training sample, tagged by the sample's label. It keeps a sorted list of the K smallest distances, each with its label, for the current test sample. The list feeds the vote stage.

---
 rtl/knn_pkg.sv | 26 ++
 rtl/knn_topk_insert.sv | 51 +++++
 rtl/update_knn_acc_topk.sv | 127 ++++++++++++
 tb/tb_update_knn_acc_topk.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types, default widths and saturating add for the KNN distance/top-K datapath.
package knn_pkg;

  localparam int PROD_WIDTH_DEF  = 32;
  localparam int SUM_WIDTH_DEF   = 40;
  localparam int K_DEF           = 3;
  localparam int LABEL_WIDTH_DEF = 4;

  localparam logic [SUM_WIDTH_DEF-1:0] EMPTY_DIST = '1;

  typedef enum logic {
    S_ACC = 1'b0,
    S_INS = 1'b1
  } knn_state_e;

  // Operands are zero-extended to 64 bits; the result clamps at max (widths below 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max}) return max;
    else                 return s[63:0];
  endfunction

endpackage

// File: rtl/knn_topk_insert.sv
// Combinational K-way compare/shift network: inserts (dist_new, lab_new) into a sorted list.
module knn_topk_insert
  import knn_pkg::*;
#(
  parameter int K           = K_DEF,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int LABEL_WIDTH = LABEL_WIDTH_DEF
) (
  input  logic [K*SUM_WIDTH-1:0]   list_dist,
  input  logic [K*LABEL_WIDTH-1:0] list_label,
  input  logic [SUM_WIDTH-1:0]     dist_new,
  input  logic [LABEL_WIDTH-1:0]   lab_new,
  output logic [K*SUM_WIDTH-1:0]   nxt_dist,
  output logic [K*LABEL_WIDTH-1:0] nxt_label
);

  logic [K-1:0]                   lt;
  logic [K:0]                     lt_ext;
  logic [(K+1)*SUM_WIDTH-1:0]     dist_ext;
  logic [(K+1)*LABEL_WIDTH-1:0]   label_ext;

  // Strict compare keeps ties behind existing entries; the list is sorted so lt is a
  // thermometer and the insertion point is where it first rises.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      lt[i] = dist_new < list_dist[i*SUM_WIDTH +: SUM_WIDTH];
    end
  end

  // Extended vectors place entry i-1 at slot i so the shift source needs no i==0 special case.
  assign lt_ext    = {lt, 1'b0};
  assign dist_ext  = {list_dist, dist_new};
  assign label_ext = {list_label, lab_new};

  always_comb begin
    nxt_dist  = list_dist;
    nxt_label = list_label;
    for (int i = 0; i < K; i++) begin
      if (lt[i]) begin
        if (lt_ext[i]) begin
          nxt_dist[i*SUM_WIDTH +: SUM_WIDTH]       = dist_ext[i*SUM_WIDTH +: SUM_WIDTH];
          nxt_label[i*LABEL_WIDTH +: LABEL_WIDTH]  = label_ext[i*LABEL_WIDTH +: LABEL_WIDTH];
        end else begin
          nxt_dist[i*SUM_WIDTH +: SUM_WIDTH]       = dist_new;
          nxt_label[i*LABEL_WIDTH +: LABEL_WIDTH]  = lab_new;
        end
      end
    end
  end

endmodule

// File: rtl/update_knn_acc_topk.sv
// Accumulates product terms into per-sample distances and keeps the K smallest with labels.
//
//   state | meaning
//   S_ACC | summing product terms; in_rdy high
//   S_INS | one bubble cycle: dist_new inserted into the top-K list, upd_done pulses after
module update_knn_acc_topk
  import knn_pkg::*;
#(
  parameter int PROD_WIDTH  = PROD_WIDTH_DEF,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int K           = K_DEF,
  parameter int LABEL_WIDTH = LABEL_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic                     clear,
  input  logic                     prod_vld,
  input  logic [PROD_WIDTH-1:0]    prod,
  input  logic                     prod_last,
  input  logic [LABEL_WIDTH-1:0]   label_in,
  output logic                     in_rdy,
  output logic [K*SUM_WIDTH-1:0]   topk_dist,
  output logic [K*LABEL_WIDTH-1:0] topk_label,
  output logic                     upd_done
);

  localparam logic [63:0] SUM_MAX = (64'd1 << SUM_WIDTH) - 64'd1;

  knn_state_e               state_q, state_d;
  logic [SUM_WIDTH-1:0]     acc_q, acc_d;
  logic [SUM_WIDTH-1:0]     dist_new_q, dist_new_d;
  logic [LABEL_WIDTH-1:0]   lab_new_q, lab_new_d;
  logic [K*SUM_WIDTH-1:0]   topk_dist_q, topk_dist_d;
  logic [K*LABEL_WIDTH-1:0] topk_label_q, topk_label_d;
  logic                     upd_done_q, upd_done_d;

  logic [K*SUM_WIDTH-1:0]   ins_dist;
  logic [K*LABEL_WIDTH-1:0] ins_label;
  logic [63:0]              sum64;
  logic [SUM_WIDTH-1:0]     sum;

  knn_topk_insert #(
    .K           (K),
    .SUM_WIDTH   (SUM_WIDTH),
    .LABEL_WIDTH (LABEL_WIDTH)
  ) u_insert (
    .list_dist  (topk_dist_q),
    .list_label (topk_label_q),
    .dist_new   (dist_new_q),
    .lab_new    (lab_new_q),
    .nxt_dist   (ins_dist),
    .nxt_label  (ins_label)
  );

  assign sum64 = sat_add({{(64-SUM_WIDTH){1'b0}}, acc_q},
                         {{(64-PROD_WIDTH){1'b0}}, prod},
                         SUM_MAX);
  assign sum   = sum64[SUM_WIDTH-1:0];

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    dist_new_d   = dist_new_q;
    lab_new_d    = lab_new_q;
    topk_dist_d  = topk_dist_q;
    topk_label_d = topk_label_q;
    upd_done_d   = upd_done_q;
    if (ce) begin
      upd_done_d = 1'b0;
      if (clear) begin
        state_d      = S_ACC;
        acc_d        = '0;
        topk_dist_d  = '1;
        topk_label_d = '0;
      end else begin
        case (state_q)
          S_ACC: begin
            if (prod_vld) begin
              if (prod_last) begin
                dist_new_d = sum;
                lab_new_d  = label_in;
                acc_d      = '0;
                state_d    = S_INS;
              end else begin
                acc_d = sum;
              end
            end
          end
          S_INS: begin
            topk_dist_d  = ins_dist;
            topk_label_d = ins_label;
            upd_done_d   = 1'b1;
            state_d      = S_ACC;
          end
          default: state_d = S_ACC;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_ACC;
      acc_q        <= '0;
      dist_new_q   <= '1;
      lab_new_q    <= '0;
      topk_dist_q  <= '1;
      topk_label_q <= '0;
      upd_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      dist_new_q   <= dist_new_d;
      lab_new_q    <= lab_new_d;
      topk_dist_q  <= topk_dist_d;
      topk_label_q <= topk_label_d;
      upd_done_q   <= upd_done_d;
    end
  end

  assign in_rdy     = (state_q == S_ACC);
  assign topk_dist  = topk_dist_q;
  assign topk_label = topk_label_q;
  assign upd_done   = upd_done_q;

endmodule

// File: tb/tb_update_knn_acc_topk.sv
// Directed bench for update_knn_acc_topk with hand-computed expected lists.
module tb_update_knn_acc_topk;

  localparam int SW = 40;
  localparam int LW = 4;
  localparam int KK = 3;
  localparam logic [63:0] E = 64'h00FF_FFFF_FFFF;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           ce;
  logic           clear;
  logic           prod_vld;
  logic [31:0]    prod;
  logic           prod_last;
  logic [LW-1:0]  label_in;
  logic           in_rdy;
  logic [KK*SW-1:0] topk_dist;
  logic [KK*LW-1:0] topk_label;
  logic           upd_done;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int pulses_base;

  update_knn_acc_topk dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .clear      (clear),
    .prod_vld   (prod_vld),
    .prod       (prod),
    .prod_last  (prod_last),
    .label_in   (label_in),
    .in_rdy     (in_rdy),
    .topk_dist  (topk_dist),
    .topk_label (topk_label),
    .upd_done   (upd_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && ce && upd_done) pulses <= pulses + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic l, input logic [3:0] lab);
    prod_vld  = 1'b1;
    prod      = p;
    prod_last = l;
    label_in  = lab;
    tick();
    prod_vld  = 1'b0;
    prod_last = 1'b0;
  endtask

  task automatic check_list(input string tag,
                            input logic [63:0] d0, input logic [3:0] l0,
                            input logic [63:0] d1, input logic [3:0] l1,
                            input logic [63:0] d2, input logic [3:0] l2);
    chk({tag, "_d0"}, 64'(topk_dist[0*SW +: SW]), d0);
    chk({tag, "_l0"}, 64'(topk_label[0*LW +: LW]), 64'(l0));
    chk({tag, "_d1"}, 64'(topk_dist[1*SW +: SW]), d1);
    chk({tag, "_l1"}, 64'(topk_label[1*LW +: LW]), 64'(l1));
    chk({tag, "_d2"}, 64'(topk_dist[2*SW +: SW]), d2);
    chk({tag, "_l2"}, 64'(topk_label[2*LW +: LW]), 64'(l2));
  endtask

  // Single-term sample: last accepted at t, bubble at t+1, result at t+2.
  task automatic sample(input string tag, input logic [31:0] p, input logic [3:0] lab);
    push(p, 1'b1, lab);
    chk({tag, "_rdy_low"}, 64'(in_rdy), 64'd0);
    tick();
    chk({tag, "_upd"}, 64'(upd_done), 64'd1);
    chk({tag, "_rdy_high"}, 64'(in_rdy), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; clear = 1'b0; prod_vld = 1'b0;
    prod = '0; prod_last = 1'b0; label_in = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();

    // 1: reset state
    check_list("rst", E, 0, E, 0, E, 0);
    chk("rst_rdy", 64'(in_rdy), 64'd1);
    chk("rst_upd", 64'(upd_done), 64'd0);

    // 2: multi-term sample 10+20+30+40 = 100, label 5
    pulses_base = pulses;
    push(10, 1'b0, 0);
    push(20, 1'b0, 0);
    push(30, 1'b0, 0);
    push(40, 1'b1, 5);
    chk("t2_rdy_low", 64'(in_rdy), 64'd0);
    chk("t2_upd_early", 64'(upd_done), 64'd0);
    check_list("t2_hold", E, 0, E, 0, E, 0);
    tick();
    chk("t2_upd", 64'(upd_done), 64'd1);
    chk("t2_rdy_high", 64'(in_rdy), 64'd1);
    check_list("t2", 100, 5, E, 0, E, 0);
    tick();
    chk("t2_upd_one", 64'(upd_done), 64'd0);

    // 3: ordered insertion, 200 drops off the end
    sample("t3a", 50, 2);
    check_list("t3a", 50, 2, 100, 5, E, 0);
    sample("t3b", 200, 7);
    check_list("t3b", 50, 2, 100, 5, 200, 7);
    sample("t3c", 75, 1);
    check_list("t3c", 50, 2, 75, 1, 100, 5);
    tick();
    chk("t3_pulses", 64'(pulses - pulses_base), 64'd4);

    // 4: tie goes behind the existing equal entry
    sample("t4", 75, 9);
    check_list("t4", 50, 2, 75, 1, 75, 9);

    // 5: saturation, list unchanged but upd_done still pulses
    for (int i = 0; i < 299; i++) push(32'hFFFF_FFFF, 1'b0, 0);
    sample("t5", 32'hFFFF_FFFF, 3);
    check_list("t5", 50, 2, 75, 1, 75, 9);
    chk("t5_dist_new", 64'(dut.dist_new_q), 64'h00FF_FFFF_FFFF);
    sample("t5b", 60, 4);
    check_list("t5b", 50, 2, 60, 4, 75, 1);

    // 6a: clear during S_INS wins over the insert
    push(10, 1'b1, 6);
    chk("t6a_rdy_low", 64'(in_rdy), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_list("t6a", E, 0, E, 0, E, 0);
    chk("t6a_upd", 64'(upd_done), 64'd0);
    chk("t6a_rdy", 64'(in_rdy), 64'd1);
    tick();
    chk("t6a_upd2", 64'(upd_done), 64'd0);

    // 6b: ce low for three cycles in S_INS freezes everything
    push(30, 1'b1, 1);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6b_rdy", 64'(in_rdy), 64'd0);
      chk("t6b_upd", 64'(upd_done), 64'd0);
      chk("t6b_d0", 64'(topk_dist[0 +: SW]), E);
    end
    ce = 1'b1;
    tick();
    chk("t6b_upd_go", 64'(upd_done), 64'd1);
    check_list("t6b", 30, 1, E, 0, E, 0);
    ce = 1'b0;
    tick();
    chk("t6b_upd_hold", 64'(upd_done), 64'd1);
    ce = 1'b1;
    tick();
    chk("t6b_upd_drop", 64'(upd_done), 64'd0);

    // 6c: products offered while in_rdy is low are ignored
    push(40, 1'b1, 2);
    push(500, 1'b0, 0);
    chk("t6c_upd", 64'(upd_done), 64'd1);
    check_list("t6c", 30, 1, 40, 2, E, 0);
    sample("t6c_next", 7, 8);
    check_list("t6c_next", 7, 8, 30, 1, 40, 2);

    // clear discards a product accepted in the same cycle
    clear = 1'b1;
    push(1000, 1'b0, 0);
    clear = 1'b0;
    check_list("clr", E, 0, E, 0, E, 0);
    sample("clr_acc", 5, 3);
    check_list("clr_acc", 5, 3, E, 0, E, 0);

    // async reset mid-insert empties the list
    push(3, 1'b1, 1);
    #2 reset_n = 1'b0;
    #1;
    check_list("arst", E, 0, E, 0, E, 0);
    chk("arst_rdy", 64'(in_rdy), 64'd1);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
